// File: rtl/io_port_bank.sv
// io_port_bank: NUM_IN input and NUM_OUT output handshake channels on one CPU port.
// Define IO_PORT_ERR_FLAGS_EN to build the sticky underrun/overrun register.
module io_port_bank #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 4,
  parameter int NUM_OUT = 4,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'hF0
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic                      cpu_rd,
  input  logic                      cpu_wr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_rvalid,
  input  logic [NUM_IN*DATA_W-1:0]  ext_in_data,
  input  logic [NUM_IN-1:0]         ext_in_valid,
  output logic [NUM_IN-1:0]         ext_in_ack,
  output logic [NUM_OUT*DATA_W-1:0] ext_out_data,
  output logic [NUM_OUT-1:0]        ext_out_valid,
  input  logic [NUM_OUT-1:0]        ext_out_ready
);

  logic [DATA_W-1:0]  inReg [NUM_IN];
  logic [NUM_IN-1:0]  inFull;
  logic [NUM_IN-1:0]  rdHitIn;
  logic [NUM_IN-1:0]  takeIn;
  logic [DATA_W-1:0]  outReg [NUM_OUT];
  logic [NUM_OUT-1:0] outPend;
  logic [NUM_OUT-1:0] wrHitOut;
  logic [DATA_W-1:0]  status;
  logic [DATA_W-1:0]  rdNext;

  // A read of a FULL channel frees it in the same cycle a new word arrives
  always_comb begin
    rdHitIn = '0;
    takeIn = '0;
    wrHitOut = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rdHitIn[i] = cpu_rd && (cpu_addr == ADDR_W'(i));
      takeIn[i] = ext_in_valid[i] && (!inFull[i] || rdHitIn[i]);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      wrHitOut[j] = cpu_wr && (cpu_addr == ADDR_W'(j));
    end
  end

  always_comb begin
    status = '0;
    status[NUM_IN-1:0] = inFull;
    status[NUM_IN +: NUM_OUT] = outPend;
  end

`ifdef IO_PORT_ERR_FLAGS_EN
  localparam logic [ADDR_W-1:0] ERR_ADDR = STATUS_ADDR + 1'b1;
  logic [DATA_W-1:0] errReg;
  logic [DATA_W-1:0] errNew;
  logic              errRead;

  assign errRead = cpu_rd && (cpu_addr == ERR_ADDR);

  always_comb begin
    errNew = '0;
    errNew[NUM_IN-1:0] = rdHitIn & ~inFull;
    errNew[NUM_IN +: NUM_OUT] = wrHitOut & outPend;
  end

  // Fresh events win over the clearing read
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      errReg <= '0;
    end else begin
      errReg <= (errRead ? '0 : errReg) | errNew;
    end
  end
`endif

  always_comb begin
    rdNext = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cpu_addr == ADDR_W'(i)) rdNext = inReg[i];
    end
    if (cpu_addr == STATUS_ADDR) rdNext = status;
`ifdef IO_PORT_ERR_FLAGS_EN
    if (errRead) rdNext = errReg;
`endif
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cpu_rdata <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) cpu_rdata <= rdNext;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      inFull <= '0;
      ext_in_ack <= '0;
      for (int i = 0; i < NUM_IN; i++) inReg[i] <= '0;
    end else begin
      ext_in_ack <= takeIn;
      for (int i = 0; i < NUM_IN; i++) begin
        if (takeIn[i]) begin
          inReg[i] <= ext_in_data[i*DATA_W +: DATA_W];
          inFull[i] <= 1'b1;
        end else if (rdHitIn[i]) begin
          inFull[i] <= 1'b0;
        end
      end
    end
  end

  // A same-cycle write re-arms PEND after ready retires the old word
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      outPend <= '0;
      for (int j = 0; j < NUM_OUT; j++) outReg[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (wrHitOut[j]) begin
          outReg[j] <= cpu_wdata;
          outPend[j] <= 1'b1;
        end else if (ext_out_ready[j]) begin
          outPend[j] <= 1'b0;
        end
      end
    end
  end

  assign ext_out_valid = outPend;

  for (genvar j = 0; j < NUM_OUT; j++) begin : gOut
    assign ext_out_data[j*DATA_W +: DATA_W] = outReg[j];
  end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed and randomized checks of io_port_bank
// against a channel-level reference model.
module tb_io_port_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [31:0] ext_in_data;
  logic [3:0]  ext_in_valid;
  logic [3:0]  ext_in_ack;
  logic [31:0] ext_out_data;
  logic [3:0]  ext_out_valid;
  logic [3:0]  ext_out_ready;

  int tests = 0;
  int fails = 0;

`ifdef IO_PORT_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [7:0] mIn [4];
  logic [7:0] mOut [4];
  logic [3:0] mFull, mPend, mAck;
  logic [7:0] mErr, mRdata;
  logic       mRvalid;

  always #5 clk = ~clk;

  io_port_bank dut (
    .clk(clk),
    .Reset(rst_n),
    .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .ext_in_data(ext_in_data),
    .ext_in_valid(ext_in_valid),
    .ext_in_ack(ext_in_ack),
    .ext_out_data(ext_out_data),
    .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mIn[i] = 8'h00;
      mOut[i] = 8'h00;
    end
    mFull = 4'h0;
    mPend = 4'h0;
    mAck = 4'h0;
    mErr = 8'h00;
    mRdata = 8'h00;
    mRvalid = 1'b0;
  endtask

  task automatic idle();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = 8'h00;
    cpu_wdata = 8'h00;
    ext_in_valid = 4'h0;
    ext_out_ready = 4'h0;
  endtask

  function automatic logic [31:0] expOut();
    return {mOut[3], mOut[2], mOut[1], mOut[0]};
  endfunction

  // Advance one clock, updating the model from the channel rules
  task automatic step();
    logic [7:0] nIn [4];
    logic [7:0] nOut [4];
    logic [3:0] nFull, nPend, nAck;
    logic [7:0] nErr, nRdata;
    logic       nRvalid, isCh, got;
    logic [1:0] ai;
    nIn = mIn;
    nOut = mOut;
    nFull = mFull;
    nPend = mPend;
    nErr = mErr;
    nRdata = mRdata;
    nAck = 4'h0;
    ai = cpu_addr[1:0];
    isCh = (cpu_addr < 8'd4);
    nRvalid = cpu_rd;
    if (cpu_rd) begin
      if (isCh) nRdata = mIn[ai];
      else if (cpu_addr == 8'hF0) nRdata = {mPend, mFull};
      else if (ERR_EN && cpu_addr == 8'hF1) nRdata = mErr;
      else nRdata = 8'h00;
      if (ERR_EN && cpu_addr == 8'hF1) nErr = 8'h00;
      if (ERR_EN && isCh && !mFull[ai]) nErr[ai] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      got = ext_in_valid[i] &&
            (!mFull[i] || (cpu_rd && cpu_addr == 8'(i)));
      nAck[i] = got;
      if (got) begin
        nIn[i] = ext_in_data[i*8 +: 8];
        nFull[i] = 1'b1;
      end else if (cpu_rd && cpu_addr == 8'(i)) begin
        nFull[i] = 1'b0;
      end
    end
    if (ERR_EN && cpu_wr && isCh && mPend[ai]) nErr[4 + ai] = 1'b1;
    nPend = nPend & ~ext_out_ready;
    if (cpu_wr && isCh) begin
      nOut[ai] = cpu_wdata;
      nPend[ai] = 1'b1;
    end
    @(posedge clk);
    #1;
    mIn = nIn;
    mOut = nOut;
    mFull = nFull;
    mPend = nPend;
    mAck = nAck;
    mErr = nErr;
    mRdata = nRdata;
    mRvalid = nRvalid;
  endtask

  task automatic rd(input logic [7:0] a);
    cpu_rd = 1'b1;
    cpu_addr = a;
    step();
    cpu_rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cpu_wr = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      cpu_rd = 1'($urandom);
      cpu_wr = 1'($urandom);
      cpu_addr = 8'($urandom);
      cpu_wdata = 8'($urandom);
      ext_in_data = $urandom;
      ext_in_valid = 4'($urandom);
      ext_out_ready = 4'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if ({cpu_rvalid, cpu_rdata, ext_in_ack, ext_out_valid,
           ext_out_data} !== 49'h0) begin
        fails++;
        $display("FAIL reset_hold: rv=%b rd=%h ack=%h ov=%h od=%h want all 0",
                 cpu_rvalid, cpu_rdata, ext_in_ack, ext_out_valid,
                 ext_out_data);
      end
    end
    idle();
    rst_n = 1'b1;
    step();
    tests++;
    if ({cpu_rvalid, cpu_rdata, ext_in_ack, ext_out_valid,
         ext_out_data} !== 49'h0) begin
      fails++;
      $display("FAIL reset_release: rv=%b rd=%h ack=%h ov=%h want all 0",
               cpu_rvalid, cpu_rdata, ext_in_ack, ext_out_valid);
    end
    rd(8'h05);
    tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00) begin
      fails++;
      $display("FAIL first_read: rv=%b rd=%h want 1/00",
               cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_input();
    ext_in_data = 32'h005A_0000;
    ext_in_valid = 4'b0100;
    step();
    tests++;
    if (ext_in_ack !== 4'b0100) begin
      fails++;
      $display("FAIL in_ack: got %b want 0100", ext_in_ack);
    end
    ext_in_valid = 4'h0;
    step();
    tests++;
    if (ext_in_ack !== 4'b0000) begin
      fails++;
      $display("FAIL in_ack_once: got %b want 0000", ext_in_ack);
    end
    rd(8'hF0);
    tests++;
    if (cpu_rdata !== 8'h04) begin
      fails++;
      $display("FAIL in_status: got %h want 04", cpu_rdata);
    end
    rd(8'h02);
    tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin
      fails++;
      $display("FAIL in_data: rv=%b rd=%h want 1/5a", cpu_rvalid, cpu_rdata);
    end
    rd(8'hF0);
    tests++;
    if (cpu_rdata !== 8'h00) begin
      fails++;
      $display("FAIL in_status_clr: got %h want 00", cpu_rdata);
    end
    step();
    tests++;
    if (cpu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rvalid_pulse: got %b want 0", cpu_rvalid);
    end
  endtask

  task automatic test_output();
    wr(8'h01, 8'hC3);
    tests++;
    if (ext_out_valid !== 4'b0010 || ext_out_data[15:8] !== 8'hC3) begin
      fails++;
      $display("FAIL out_load: ov=%b d=%h want 0010/c3",
               ext_out_valid, ext_out_data[15:8]);
    end
    rd(8'hF0);
    tests++;
    if (cpu_rdata !== 8'h20) begin
      fails++;
      $display("FAIL out_status: got %h want 20", cpu_rdata);
    end
    ext_out_ready = 4'b0010;
    step();
    ext_out_ready = 4'h0;
    tests++;
    if (ext_out_valid !== 4'b0000 || ext_out_data[15:8] !== 8'hC3) begin
      fails++;
      $display("FAIL out_accept: ov=%b d=%h want 0000/c3",
               ext_out_valid, ext_out_data[15:8]);
    end
  endtask

  task automatic test_back_to_back();
    ext_in_data = 32'h0000_0011;
    ext_in_valid = 4'b0001;
    step();
    ext_in_valid = 4'h0;
    step();
    ext_in_data = 32'h0000_0022;
    ext_in_valid = 4'b0001;
    rd(8'h00);
    ext_in_valid = 4'h0;
    tests++;
    if (cpu_rdata !== 8'h11 || ext_in_ack !== 4'b0001) begin
      fails++;
      $display("FAIL b2b_read: rd=%h ack=%b want 11/0001",
               cpu_rdata, ext_in_ack);
    end
    rd(8'hF0);
    tests++;
    if (cpu_rdata !== 8'h01) begin
      fails++;
      $display("FAIL b2b_full: got %h want 01", cpu_rdata);
    end
    rd(8'h00);
    tests++;
    if (cpu_rdata !== 8'h22) begin
      fails++;
      $display("FAIL b2b_next: got %h want 22", cpu_rdata);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [10];
    pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07,
             8'hF0, 8'hF1, 8'hF2, 8'h80};
    for (int c = 0; c < 400; c++) begin
      cpu_addr = pool[$urandom_range(9)];
      cpu_rd = ($urandom_range(99) < 40);
      cpu_wr = ($urandom_range(99) < 30);
      cpu_wdata = 8'($urandom);
      ext_in_data = $urandom;
      ext_in_valid = 4'($urandom);
      ext_out_ready = 4'($urandom);
      step();
      tests++;
      if (cpu_rvalid !== mRvalid || (mRvalid && cpu_rdata !== mRdata)) begin
        fails++;
        $display("FAIL rnd_read c%0d: rv=%b rd=%h want %b/%h",
                 c, cpu_rvalid, cpu_rdata, mRvalid, mRdata);
      end
      tests++;
      if (ext_in_ack !== mAck || ext_out_valid !== mPend ||
          ext_out_data !== expOut()) begin
        fails++;
        $display("FAIL rnd_chan c%0d: ack=%b ov=%b od=%h want %b/%b/%h",
                 c, ext_in_ack, ext_out_valid, ext_out_data,
                 mAck, mPend, expOut());
      end
    end
    idle();
    step();
  endtask

  task automatic test_err();
    ext_out_ready = 4'hF;
    rd(8'h03);
    rd(8'hF1);
    ext_out_ready = 4'h0;
    step();
`ifdef IO_PORT_ERR_FLAGS_EN
    rd(8'h03);
    wr(8'h00, 8'hA1);
    wr(8'h00, 8'hA2);
    rd(8'hF1);
    tests++;
    if (cpu_rdata !== 8'h18) begin
      fails++;
      $display("FAIL err_read: got %h want 18", cpu_rdata);
    end
    rd(8'hF1);
    tests++;
    if (cpu_rdata !== 8'h00) begin
      fails++;
      $display("FAIL err_clear: got %h want 00", cpu_rdata);
    end
`else
    rd(8'h03);
    wr(8'h00, 8'hA1);
    wr(8'h00, 8'hA2);
    rd(8'hF1);
    tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00) begin
      fails++;
      $display("FAIL err_unmapped: rv=%b rd=%h want 1/00",
               cpu_rvalid, cpu_rdata);
    end
`endif
    ext_out_ready = 4'hF;
    step();
    ext_out_ready = 4'h0;
  endtask

  task automatic test_reset_mid();
    ext_in_data = 32'h0000_7700;
    ext_in_valid = 4'b0010;
    step();
    ext_in_valid = 4'h0;
    wr(8'h02, 8'h9E);
    tests++;
    if (ext_out_valid !== 4'b0100) begin
      fails++;
      $display("FAIL mid_setup: ov=%b want 0100", ext_out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (ext_out_valid !== 4'h0 || ext_out_data !== 32'h0 ||
        ext_in_ack !== 4'h0 || cpu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_async: ov=%b od=%h ack=%b rv=%b want 0",
               ext_out_valid, ext_out_data, ext_in_ack, cpu_rvalid);
    end
    ext_in_valid = 4'hF;
    ext_out_ready = 4'hF;
    @(posedge clk);
    #1;
    tests++;
    if (ext_in_ack !== 4'h0 || ext_out_valid !== 4'h0) begin
      fails++;
      $display("FAIL mid_hold: ack=%b ov=%b want 0/0",
               ext_in_ack, ext_out_valid);
    end
    idle();
    rst_n = 1'b1;
    rd(8'hF0);
    tests++;
    if (cpu_rdata !== 8'h00 || ext_in_ack !== 4'h0) begin
      fails++;
      $display("FAIL mid_status: rd=%h ack=%b want 00/0",
               cpu_rdata, ext_in_ack);
    end
    rd(8'h01);
    tests++;
    if (cpu_rdata !== 8'h00) begin
      fails++;
      $display("FAIL mid_data: got %h want 00", cpu_rdata);
    end
  endtask

  initial begin
    idle();
    ext_in_data = 32'h0;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_input();
    test_output();
    test_back_to_back();
    test_random();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
